// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path (and the planned TX successor).
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic [1:0] DATA_BITS_5 = 2'b00;
    localparam logic [1:0] DATA_BITS_6 = 2'b01;
    localparam logic [1:0] DATA_BITS_7 = 2'b10;
    localparam logic [1:0] DATA_BITS_8 = 2'b11;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    function automatic logic [3:0] data_bits_count(input logic [1:0] code);
        logic [3:0] n;
        case (code)
            DATA_BITS_5: n = 4'd5;
            DATA_BITS_6: n = 4'd6;
            DATA_BITS_7: n = 4'd7;
            DATA_BITS_8: n = 4'd8;
            default:     n = 4'd8;
        endcase
        return n;
    endfunction

    // Unused upper data bits are zero, so they do not disturb the XOR.
    function automatic logic parity_error(input logic [7:0] data, input logic pbit,
                                          input logic ptype);
        logic ones;
        logic err;
        ones = ^data ^ pbit;
        case (ptype)
            PARITY_EVEN: err = ones;
            PARITY_ODD:  err = ~ones;
            default:     err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Oversample clock-enable: one-cycle tick every max(div,1) clocks.
// The divisor is reloaded only at terminal count, so changes land at the next wrap.
module uart_baud_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_reload;

    assign w_reload = (i_div == '0) ? '0 : i_div - DIV_W'(1);
    assign o_tick   = (r_cnt == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt == '0) begin
            r_cnt <= w_reload;
        end else begin
            r_cnt <= r_cnt - DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_engine.sv
// Oversampled UART receiver with majority-vote sampling, false-start rejection
// and a valid/ready output register with parity, stop and overrun reporting.
//
// state  | meaning
// IDLE   | waiting for a synchronised 1->0 edge
// START  | checking the start bit; a high vote rejects it as a glitch
// DATA   | shifting data bits in LSB first
// PARITY | checking the parity bit
// STOP   | sampling one or two stop bits; frame completes at the last third vote
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_uart_clk,
    input  logic             i_uart_rst_n,
    input  logic             i_uart_rx_sdata,
    input  logic [DIV_W-1:0] i_uart_baud_div,
    input  logic [1:0]       i_uart_data_bits,
    input  logic             i_uart_parity_enable,
    input  logic             i_uart_parity_type,
    input  logic             i_uart_stop_bits,
    input  logic             i_uart_rx_ready,
    output logic             o_uart_rx_valid,
    output logic [7:0]       o_uart_rx_pdata,
    output logic             o_uart_parity_error,
    output logic             o_uart_stop_error,
    output logic             o_uart_overrun,
    output logic             o_uart_rx_busy
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_V1   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_V2   = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0] OS_V3   = OS_W'(OVERSAMPLE / 2 + 1);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

    uart_state_e r_state, w_next;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_d;
    logic                   w_rx;
    logic                   w_fall;
    logic                   w_tick;

    logic [OS_W-1:0] r_os;
    logic [1:0]      r_vote;
    logic            w_maj;
    logic            w_vote3;
    logic            w_end;
    logic            w_complete;

    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic       r_stop_cnt;
    logic       r_par_err;
    logic       r_stop_err;

    logic [2:0] r_cfg_last;
    logic       r_cfg_par_en;
    logic       r_cfg_ptype;
    logic       r_cfg_stop2;

    logic       r_valid;
    logic [7:0] r_pdata;
    logic       r_perr_q;
    logic       r_serr_q;
    logic       r_ovr;

    uart_baud_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .i_clk   (i_uart_clk),
        .i_rst_n (i_uart_rst_n),
        .i_div   (i_uart_baud_div),
        .o_tick  (w_tick)
    );

    assign w_rx    = r_sync[SYNC_STAGES-1];
    assign w_fall  = r_rx_d & ~w_rx;
    assign w_maj   = (r_vote[0] & r_vote[1]) | (r_vote[0] & w_rx) | (r_vote[1] & w_rx);
    assign w_vote3 = w_tick && (r_os == OS_V3);
    assign w_end   = w_tick && (r_os == OS_LAST);
    assign w_complete = (r_state == ST_STOP) && w_vote3 && (r_stop_cnt == r_cfg_stop2);

    always_ff @(posedge i_uart_clk or negedge i_uart_rst_n) begin
        if (!i_uart_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_fall) w_next = ST_START;
            ST_START: begin
                if (w_vote3 && w_maj) w_next = ST_IDLE;
                else if (w_end)       w_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_end && (r_bit_cnt == r_cfg_last))
                    w_next = r_cfg_par_en ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: if (w_end) w_next = ST_STOP;
            ST_STOP:   if (w_complete) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_uart_clk or negedge i_uart_rst_n) begin
        if (!i_uart_rst_n) begin
            r_sync       <= '1;
            r_rx_d       <= 1'b1;
            r_os         <= '0;
            r_vote       <= '0;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_stop_cnt   <= 1'b0;
            r_par_err    <= 1'b0;
            r_stop_err   <= 1'b0;
            r_cfg_last   <= 3'd7;
            r_cfg_par_en <= 1'b0;
            r_cfg_ptype  <= 1'b0;
            r_cfg_stop2  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_uart_rx_sdata};
            r_rx_d <= w_rx;
            if (r_state == ST_IDLE) begin
                // Config is frozen here so mid-frame register writes cannot corrupt the frame.
                if (w_fall) begin
                    r_cfg_last   <= 3'(data_bits_count(i_uart_data_bits) - 4'd1);
                    r_cfg_par_en <= i_uart_parity_enable;
                    r_cfg_ptype  <= i_uart_parity_type;
                    r_cfg_stop2  <= i_uart_stop_bits;
                    r_os         <= '0;
                    r_shift      <= '0;
                    r_bit_cnt    <= '0;
                    r_stop_cnt   <= 1'b0;
                    r_par_err    <= 1'b0;
                    r_stop_err   <= 1'b0;
                end
            end else if (w_tick) begin
                r_os <= (r_os == OS_LAST) ? '0 : r_os + OS_W'(1);
                if (r_os == OS_V1) r_vote[0] <= w_rx;
                if (r_os == OS_V2) r_vote[1] <= w_rx;
                if (w_vote3) begin
                    case (r_state)
                        ST_DATA:   r_shift[r_bit_cnt] <= w_maj;
                        ST_PARITY: r_par_err <= parity_error(r_shift, w_maj, r_cfg_ptype);
                        ST_STOP:   if (!w_maj) r_stop_err <= 1'b1;
                        default:   ;
                    endcase
                end
                if (w_end) begin
                    if (r_state == ST_DATA) r_bit_cnt  <= r_bit_cnt + 3'd1;
                    if (r_state == ST_STOP) r_stop_cnt <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_uart_clk or negedge i_uart_rst_n) begin
        if (!i_uart_rst_n) begin
            r_valid  <= 1'b0;
            r_pdata  <= '0;
            r_perr_q <= 1'b0;
            r_serr_q <= 1'b0;
            r_ovr    <= 1'b0;
        end else if (w_complete) begin
            if (r_valid && !i_uart_rx_ready) begin
                r_ovr <= 1'b1;
            end else begin
                r_valid  <= 1'b1;
                r_pdata  <= r_shift;
                r_perr_q <= r_par_err;
                r_serr_q <= r_stop_err | ~w_maj;
                if (r_valid) r_ovr <= 1'b0;
            end
        end else if (r_valid && i_uart_rx_ready) begin
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end
    end

    assign o_uart_rx_valid     = r_valid;
    assign o_uart_rx_pdata     = r_pdata;
    assign o_uart_parity_error = r_perr_q;
    assign o_uart_stop_error   = r_serr_q;
    assign o_uart_overrun      = r_ovr;
    assign o_uart_rx_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine: frame formats, errors, break, glitch, overrun, reset.
module tb_uart_rx_engine;

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic [15:0] div;
    logic [1:0]  dbits;
    logic        par_en;
    logic        ptype;
    logic        stop2;
    logic        ready;
    logic        o_valid;
    logic [7:0]  o_pdata;
    logic        o_perr;
    logic        o_serr;
    logic        o_ovr;
    logic        o_busy;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int bit_clks = 64;
    int cyc = 0;
    int n_valid_cyc = 0;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       se;
        int         cyc;
    } frame_t;
    frame_t q[$];

    uart_rx_engine dut (
        .i_uart_clk           (clk),
        .i_uart_rst_n         (rst_n),
        .i_uart_rx_sdata      (rx),
        .i_uart_baud_div      (div),
        .i_uart_data_bits     (dbits),
        .i_uart_parity_enable (par_en),
        .i_uart_parity_type   (ptype),
        .i_uart_stop_bits     (stop2),
        .i_uart_rx_ready      (ready),
        .o_uart_rx_valid      (o_valid),
        .o_uart_rx_pdata      (o_pdata),
        .o_uart_parity_error  (o_perr),
        .o_uart_stop_error    (o_serr),
        .o_uart_overrun       (o_ovr),
        .o_uart_rx_busy       (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_valid) n_valid_cyc++;
        if (o_valid && ready) q.push_back('{d: o_pdata, pe: o_perr, se: o_serr, cyc: cyc});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (bit_clks) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * bit_clks) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input bit pen,
                              input bit pt, input bit two_stop, input bit flip_par,
                              input bit stop_val);
        logic par;
        par = pt;
        for (int i = 0; i < nbits; i++) par = par ^ d[i];
        if (flip_par) par = ~par;
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(d[i]);
        if (pen) drive_bit(par);
        drive_bit(stop_val);
        if (two_stop) drive_bit(stop_val);
        rx = 1'b1;
    endtask

    task automatic pop_frame(output frame_t f);
        if (q.size() > 0) f = q.pop_front();
        else f = '{d: 8'hxx, pe: 1'bx, se: 1'bx, cyc: -1};
    endtask

    initial begin
        frame_t f;
        int c0;
        int vc0;

        rst_n = 1'b0; rx = 1'b1; ready = 1'b1; div = 16'd4;
        dbits = 2'b11; par_en = 1'b0; ptype = 1'b0; stop2 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {19'd0, o_valid, o_pdata, o_perr, o_serr, o_ovr, o_busy}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 8N1 0xA5, ready held high
        q.delete();
        c0 = cyc;
        send_frame(8'hA5, 8, 0, 0, 0, 0, 1'b1);
        idle_bits(2);
        check("a5_count", q.size(), 1);
        pop_frame(f);
        check("a5_data", f.d, 8'hA5);
        check("a5_perr", f.pe, 0);
        check("a5_serr", f.se, 0);
        check("a5_latency_window", ((f.cyc - c0) >= 615 && (f.cyc - c0) <= 620), 1);

        // 7E2
        dbits = 2'b10; par_en = 1'b1; ptype = 1'b0; stop2 = 1'b1;
        q.delete();
        send_frame(8'h3C, 7, 1, 0, 1, 0, 1'b1);
        idle_bits(2);
        send_frame(8'h3C, 7, 1, 0, 1, 1, 1'b1);
        idle_bits(2);
        check("7e2_count", q.size(), 2);
        pop_frame(f);
        check("7e2_good_data", f.d, 8'h3C);
        check("7e2_good_perr", f.pe, 0);
        check("7e2_good_serr", f.se, 0);
        pop_frame(f);
        check("7e2_bad_data", f.d, 8'h3C);
        check("7e2_bad_perr", f.pe, 1);
        check("7e2_bad_serr", f.se, 0);

        // 5O1, then stop bit forced low
        dbits = 2'b00; par_en = 1'b1; ptype = 1'b1; stop2 = 1'b0;
        q.delete();
        send_frame(8'h1F, 5, 1, 1, 0, 0, 1'b1);
        idle_bits(2);
        send_frame(8'h1F, 5, 1, 1, 0, 0, 1'b0);
        idle_bits(2);
        check("5o1_count", q.size(), 2);
        pop_frame(f);
        check("5o1_good_data", f.d, 8'h1F);
        check("5o1_good_perr", f.pe, 0);
        check("5o1_good_serr", f.se, 0);
        pop_frame(f);
        check("5o1_stop_data", f.d, 8'h1F);
        check("5o1_stop_perr", f.pe, 0);
        check("5o1_stop_serr", f.se, 1);

        // Break: line low for 20 bit times
        q.delete();
        rx = 1'b0;
        repeat (20 * bit_clks) @(negedge clk);
        check("break_count_low", q.size(), 1);
        check("break_busy_low", o_busy, 0);
        idle_bits(3);
        check("break_count_after", q.size(), 1);
        pop_frame(f);
        check("break_data", f.d, 8'h00);
        check("break_serr", f.se, 1);

        // Three-clock glitch
        vc0 = n_valid_cyc;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        check("glitch_busy_high", o_busy, 1);
        repeat (100) @(negedge clk);
        check("glitch_busy_low", o_busy, 0);
        check("glitch_no_valid", n_valid_cyc - vc0, 0);

        // Overrun with ready low
        dbits = 2'b11; par_en = 1'b0; ptype = 1'b0; stop2 = 1'b0;
        ready = 1'b0;
        q.delete();
        send_frame(8'h11, 8, 0, 0, 0, 0, 1'b1);
        idle_bits(2);
        send_frame(8'h22, 8, 0, 0, 0, 0, 1'b1);
        idle_bits(2);
        check("ovr_valid", o_valid, 1);
        check("ovr_pdata_held", o_pdata, 8'h11);
        check("ovr_flag", o_ovr, 1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        @(negedge clk);
        check("ovr_clear_valid", o_valid, 0);
        check("ovr_clear_flag", o_ovr, 0);
        check("ovr_handshake_data", q.size() > 0 ? q[0].d : 8'hxx, 8'h11);

        // Divisor 1 makes the completion cycle exact: 156 clocks after the start bit
        div = 16'd1;
        bit_clks = 16;
        repeat (20) @(negedge clk);
        q.delete();
        send_frame(8'h44, 8, 0, 0, 0, 0, 1'b1);
        idle_bits(2);
        check("held44_valid", o_valid, 1);
        check("held44_pdata", o_pdata, 8'h44);
        check("held44_ovr", o_ovr, 0);
        fork
            send_frame(8'h33, 8, 0, 0, 0, 0, 1'b1);
            begin
                repeat (156) @(negedge clk);
                ready = 1'b1;
                @(negedge clk);
                ready = 1'b0;
            end
        join
        idle_bits(2);
        check("swap_old_consumed", q.size() > 0 ? q[0].d : 8'hxx, 8'h44);
        check("swap_valid", o_valid, 1);
        check("swap_pdata", o_pdata, 8'h33);
        check("swap_ovr", o_ovr, 0);

        // Reset in the middle of the data bits
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        check("midframe_busy", o_busy, 1);
        rst_n = 1'b0;
        #1;
        check("midframe_reset_outputs",
              {19'd0, o_valid, o_pdata, o_perr, o_serr, o_ovr, o_busy}, 32'd0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        idle_bits(1);
        q.delete();
        send_frame(8'h5A, 8, 0, 0, 0, 0, 1'b1);
        idle_bits(2);
        check("post_reset_count", q.size(), 1);
        pop_frame(f);
        check("post_reset_data", f.d, 8'h5A);
        check("post_reset_perr", f.pe, 0);
        check("post_reset_serr", f.se, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_engine.md
Name: uart_rx_engine

Overview:
Parametrised single-clock UART receiver for the peripheral, replacing the divided-clock receive path.
- Oversampled at OVERSAMPLE×baud using a clock-enable tick; no generated clocks.
- Runtime-selectable data bits (5–8), parity and stop bits.
- Majority-vote bit sampling and false-start rejection.
- Valid/ready output handshake with parity, stop and overrun reporting; feeds the RX FIFO write side directly.

Parameters:
- OVERSAMPLE, 16, ticks per bit; even, ≥8.
- DIV_W, 16, width of baud divisor input.
- SYNC_STAGES, 2, synchroniser flops on serial input; ≥2.

Ports:
- i_uart_clk  in  1  system clock.
- i_uart_rst_n  in  1  reset; asynchronous, active-low.
- i_uart_rx_sdata  in  1  asynchronous serial line; idle high.
- i_uart_baud_div  in  DIV_W  clocks per oversample tick; 0 is treated as 1.
- i_uart_data_bits  in  2  00=5, 01=6, 10=7, 11=8 data bits.
- i_uart_parity_enable  in  1  parity bit present.
- i_uart_parity_type  in  1  0=even, 1=odd.
- i_uart_stop_bits  in  1  0=one stop bit, 1=two.
- i_uart_rx_ready  in  1  consumer accepts data.
- o_uart_rx_valid  out  1  received frame available.
- o_uart_rx_pdata  out  8  data, LSB-aligned, unused upper bits 0.
- o_uart_parity_error  out  1  parity mismatch for held frame.
- o_uart_stop_error  out  1  stop bit sampled 0 for held frame.
- o_uart_overrun  out  1  sticky; a frame was dropped.
- o_uart_rx_busy  out  1  FSM not IDLE.

Behaviour:
- Reset: all outputs 0. Synchroniser flops reset to 1. FSM in IDLE. Tick counter and oversample counter 0.
- Tick generator: free-running counter 0..max(div,1)−1. Tick is asserted for one clock when the counter hits the terminal count. A divisor change takes effect at the next wrap.
- Start detection: in IDLE, a synchronised 1→0 transition, checked every clock, moves to START.
  - On that transition, latch the config inputs and clear the oversample counter and shift register.
  - Config changes mid-frame are ignored.
- Sampling:
  - The oversample counter increments on each tick, 0..OVERSAMPLE−1.
  - Votes are taken at counts OVERSAMPLE/2−1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - The bit value is the majority (≥2 of 3).
  - The bit period ends on the tick at count OVERSAMPLE−1.
- FSM, states IDLE, START, DATA, PARITY, STOP:
  - START: if the vote is 1, it is a false start; return to IDLE at the voted tick with no output. Otherwise go to DATA at the end of the period.
  - DATA: shift the bits LSB first. After N bits, go to PARITY if the parity bit is enabled, else to STOP.
  - PARITY: error if the XOR of the data bits, the parity bit and parity_type is not 0.
  - STOP: one or two stop bits. A stop error is flagged if any stop vote is 0.
  - Frame completion occurs at the final stop bit's third vote; go to IDLE on that tick without waiting for the full period.
  - A new falling edge is accepted from the next clock.
- Output register:
  - Loaded on the clock after completion: pdata, parity_error and stop_error are captured together and valid is set.
  - Values are held stable while valid && !ready. Valid clears on valid && ready.
- Overrun:
  - If completion coincides with valid=1 and ready=0, the new frame is dropped, the held frame is kept and o_uart_overrun is set.
  - Overrun clears on the next valid&&ready handshake.
  - If ready=1 in the completion cycle, the old frame is consumed and the new one loaded; no overrun.
- Break (line held low): reported as data 0 with stop_error=1. The FSM then waits in IDLE for the next 1→0 edge; there is no retrigger while the line stays low.
- Asynchronous reset mid-frame: immediate return to reset state; the partial frame is discarded.
- o_uart_rx_busy is high in every state except IDLE.

Decomposition:
- Package uart_pkg:
  - FSM state enum.
  - Data-bits encoding constants.
  - Parity type constants (EVEN=0, ODD=1).
  - Function returning the bit count from the 2-bit code.
- Sub-module uart_baud_tick_gen (DIV_W): divisor in, single-cycle tick out. Reused by the planned TX successor.
- Synchroniser and majority vote stay inline.

Test Plan:
- 8N1, div=4, OVERSAMPLE=16 (64 clk/bit), send 0xA5 with ready=1 → valid pulses one cycle after stop-bit mid-sample; pdata=0xA5; both error flags 0.
- 7E2, send 0x3C with correct parity, then 0x3C with the parity bit flipped → first frame: pdata=0x3C, parity_error=0; second: parity_error=1; stop_error=0 for both.
- 5O1, send 0x1F, then 0x1F with the stop bit forced 0 → first: pdata=0x1F; second: pdata=0x1F, stop_error=1. Then hold line low for 20 bit times → exactly one frame with pdata=0x00, stop_error=1, and no further frames until the line returns high.
- Glitch low for 3 clocks (less than half a bit) in IDLE → busy asserts, then returns to IDLE; valid never asserts.
- ready=0, send 0x11 then 0x22 → pdata stays 0x11 and overrun=1. Assert ready one cycle → valid and overrun clear. Then send 0x33 with ready=1 exactly in its completion cycle → pdata=0x33, overrun=0.
- Assert reset in the middle of the data bits of a frame → all outputs 0 and busy=0 immediately. A following clean 0x5A frame is received correctly.
